// File: rtl/simon_pkg.sv
// Shared SIMON constants, types and helpers.
// Round constant, z-sequences and word rotation.
package simon_pkg;

    localparam int unsigned SIMON_W     = 32;
    localparam int unsigned SIMON_ZLEN  = 62;
    localparam int unsigned SIMON_M     = 3;
    localparam int unsigned SIMON_ROUNDS = 42;

    typedef logic [SIMON_W-1:0]    word_t;
    typedef logic [SIMON_ZLEN-1:0] zseq_t;
    typedef logic [5:0]            zidx_t;

    localparam word_t SIMON_C = 32'hFFFF_FFFC;

    // Element 0 of each sequence is the MSB.
    localparam zseq_t Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam zseq_t Z1 =
        62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam zseq_t Z2 =
        62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam zseq_t Z3 =
        62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam zseq_t Z4 =
        62'b11010001111001101011011000100000010111000011001010010011101111;

    typedef struct packed {
        logic  valid;
        word_t k;
    } step_out_t;

    function automatic word_t ror(input word_t x, input int unsigned r);
        int unsigned s;
        s = r % SIMON_W;
        if (s == 0) return x;
        return (x >> s) | (x << (SIMON_W - s));
    endfunction

endpackage

// File: rtl/key_step_comb.sv
// Combinational SIMON key-expansion step.
// Produces k[i] from k[i-m], k[i-1], k[i-3], c and one z bit.
module key_step_comb
    import simon_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned M      = 3,
    parameter int unsigned Z_LEN  = 62
) (
    input  logic [WORD_W-1:0] c,
    input  logic [Z_LEN-1:0]  z_seq,
    input  logic [5:0]        z_idx,
    input  logic [WORD_W-1:0] k_im,
    input  logic [WORD_W-1:0] k_im1,
    input  logic [WORD_W-1:0] k_im3,
    output logic [WORD_W-1:0] k_next,
    output logic              z_bad
);

    localparam logic [5:0] ZMAX = 6'(Z_LEN - 1);
    localparam bit         USE3 = (M == 4);

    logic [WORD_W-1:0] r3;
    logic [WORD_W-1:0] t0;
    logic [WORD_W-1:0] t1;
    logic [WORD_W-1:0] zw;
    logic [5:0]        zpos;
    logic              zb;

    assign r3 = {k_im1[2:0], k_im1[WORD_W-1:3]};
    assign t0 = r3 ^ (USE3 ? k_im3 : '0);
    assign t1 = t0 ^ {t0[0], t0[WORD_W-1:1]};

    // Out-of-range positions contribute a zero z bit.
    assign z_bad = (z_idx > ZMAX);
    assign zpos  = ZMAX - z_idx;
    assign zb    = z_bad ? 1'b0 : z_seq[zpos];
    assign zw    = {{(WORD_W-1){1'b0}}, zb};

    assign k_next = c ^ zw ^ k_im ^ t1;

endmodule

// File: rtl/key_schedule.sv
// One registered SIMON key-expansion step.
// Accepts a step every cycle, result one cycle later.
module key_schedule
    import simon_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned M      = 3,
    parameter int unsigned Z_LEN  = 62
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] c,
    input  logic [Z_LEN-1:0]  z_seq,
    input  logic [5:0]        z_idx,
    input  logic [WORD_W-1:0] k_im,
    input  logic [WORD_W-1:0] k_im1,
    input  logic [WORD_W-1:0] k_im3,
    output logic              out_valid,
    output logic [WORD_W-1:0] k_out
);

    logic [WORD_W-1:0] next_k;
    logic              z_bad;
    logic [WORD_W-1:0] k_d;
    logic [WORD_W-1:0] k_q;
    logic              v_d;
    logic              v_q;

    key_step_comb #(
        .WORD_W (WORD_W),
        .M      (M),
        .Z_LEN  (Z_LEN)
    ) u_step (
        .c      (c),
        .z_seq  (z_seq),
        .z_idx  (z_idx),
        .k_im   (k_im),
        .k_im1  (k_im1),
        .k_im3  (k_im3),
        .k_next (next_k),
        .z_bad  (z_bad)
    );

    // Key holds its last value while idle.
    always_comb begin
        k_d = k_q;
        v_d = in_valid;
        if (in_valid) k_d = next_k;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0;
            v_q <= 1'b0;
        end else begin
            k_q <= k_d;
            v_q <= v_d;
        end
    end

    assign k_out     = k_q;
    assign out_valid = v_q;

    always_ff @(posedge clk) begin
        if (rst_n && in_valid) begin
            assert (!z_bad)
            else $warning("key_schedule: z_idx %0d out of range", z_idx);
        end
    end

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule (M=3 and M=4 builds).
// Hand-computed vectors plus a SIMON64/96 schedule model.
module tb_key_schedule;

    localparam logic [31:0] CC = 32'hFFFF_FFFC;
    localparam logic [61:0] TZ2 =
        62'b10101111011100000011010010011000101000010001111110010110110011;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] c;
    logic [61:0] z_seq;
    logic [5:0]  z_idx;
    logic [31:0] k_im;
    logic [31:0] k_im1;
    logic [31:0] k_im3;
    logic        ov3;
    logic [31:0] ko3;
    logic        ov4;
    logic [31:0] ko4;

    int n_chk;
    int n_fail;

    logic [31:0] rk [42];

    key_schedule #(.WORD_W(32), .M(3), .Z_LEN(62)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .c         (c),
        .z_seq     (z_seq),
        .z_idx     (z_idx),
        .k_im      (k_im),
        .k_im1     (k_im1),
        .k_im3     (k_im3),
        .out_valid (ov3),
        .k_out     (ko3)
    );

    key_schedule #(.WORD_W(32), .M(4), .Z_LEN(62)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .c         (c),
        .z_seq     (z_seq),
        .z_idx     (z_idx),
        .k_im      (k_im),
        .k_im1     (k_im1),
        .k_im3     (k_im3),
        .out_valid (ov4),
        .k_out     (ko4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] d,
                         input logic [31:0] cv,
                         input logic [5:0]  zi,
                         input logic        v);
        k_im     = a;
        k_im1    = b;
        k_im3    = d;
        c        = cv;
        z_idx    = zi;
        in_valid = v;
    endtask

    function automatic logic [31:0] mdl(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input int j);
        logic [31:0] t;
        logic [31:0] zb;
        t  = (b >> 3) | (b << 29);
        t  = t ^ ((t >> 1) | (t << 31));
        zb = 32'((TZ2 >> (61 - j)) & 62'd1);
        return CC ^ zb ^ a ^ t;
    endfunction

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        z_seq    = TZ2;
        drive(0, 0, 0, 0, 0, 1'b0);

        #3;
        chk("rst_k", ko3, 32'h0);
        chk("rst_v", 32'(ov3), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Zero keys, z element 1 is 0.
        drive(0, 0, 0, CC, 6'd1, 1'b1);
        @(posedge clk); #1;
        chk("zero_v", 32'(ov3), 32'h1);
        chk("zero_k", ko3, 32'hFFFF_FFFC);

        @(negedge clk);
        drive(32'h0302_0100, 32'h1312_1110, 0, CC, 6'd0, 1'b1);
        @(posedge clk); #1;
        chk("known_k", ko3, 32'hFFAE_9DCE);

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_v", 32'(ov3), 32'h0);
        chk("idle_hold", ko3, 32'hFFAE_9DCE);

        // Three back-to-back steps.
        @(negedge clk);
        drive(0, 0, 0, CC, 6'd1, 1'b1);
        @(negedge clk);
        chk("s1_k", ko3, 32'hFFFF_FFFC);
        chk("s1_v", 32'(ov3), 32'h1);
        drive(32'h0302_0100, 32'h1312_1110, 0, CC, 6'd0, 1'b1);
        @(negedge clk);
        chk("s2_k", ko3, 32'hFFAE_9DCE);
        chk("s2_v", 32'(ov3), 32'h1);
        drive(32'hFFFF_FFFF, 0, 0, CC, 6'd0, 1'b1);
        @(negedge clk);
        chk("s3_k", ko3, 32'h0000_0002);
        chk("s3_v", 32'(ov3), 32'h1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("s_drop_v", 32'(ov3), 32'h0);
        chk("s_drop_k", ko3, 32'h0000_0002);

        // Illegal positions force zb to 0.
        drive(0, 0, 0, CC, 6'd62, 1'b1);
        @(posedge clk); #1;
        chk("ill62_k", ko3, 32'hFFFF_FFFC);
        @(negedge clk);
        drive(32'h1, 0, 0, CC, 6'd63, 1'b1);
        @(posedge clk); #1;
        chk("ill63_k", ko3, 32'hFFFF_FFFD);

        // M=4 uses k_im3, M=3 ignores it.
        @(negedge clk);
        drive(0, 0, 32'hFFFF_FFFF, 0, 6'd1, 1'b1);
        @(posedge clk); #1;
        chk("m4_ones", ko4, 32'h0);
        chk("m3_ones", ko3, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h1, 0, 6'd1, 1'b1);
        @(posedge clk); #1;
        chk("m4_one", ko4, 32'h8000_0001);
        chk("m3_one", ko3, 32'h0);

        // Reset in the middle of a stream.
        @(negedge clk);
        drive(0, 0, 0, CC, 6'd1, 1'b1);
        @(posedge clk); #1;
        chk("pre_rst_v", 32'(ov3), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_k", ko3, 32'h0);
        chk("mid_rst_v", 32'(ov3), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h0302_0100, 32'h1312_1110, 0, CC, 6'd0, 1'b1);
        @(posedge clk); #1;
        chk("post_rst_v", 32'(ov3), 32'h1);
        chk("post_rst_k", ko3, 32'hFFAE_9DCE);

        // Full SIMON64/96 schedule, one step per cycle.
        rk[0] = 32'h0302_0100;
        rk[1] = 32'h0b0a_0908;
        rk[2] = 32'h1312_1110;
        for (int i = 3; i < 42; i++)
            rk[i] = mdl(rk[i-3], rk[i-1], (i - 3) % 62);
        for (int i = 3; i < 42; i++) begin
            @(negedge clk);
            drive(rk[i-3], rk[i-1], 0, CC, 6'((i - 3) % 62), 1'b1);
            @(posedge clk); #1;
            chk($sformatf("sched_%0d", i), ko3, rk[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("end_v", 32'(ov3), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
